// File: rtl/round_arbiter.sv
// Round-robin arbiter sharing one rounding datapath between two requesters,
// with a registered operand stage and a valid/ready result stage.
// Optional result statistics counters are enabled with ROUND_ARB_STATS_EN.
module round_arbiter #(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    localparam int NRAS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_neg,
    input  logic [2*(NEXP+2)-1:0]      req_exp,
    input  logic [2*INTn-1:0]          req_sig,
    input  logic [2*(NRAS+1)-1:0]      req_ra,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_id,
    output logic                       out_neg,
    output logic [NEXP+1:0]            out_exp,
    output logic [NSIG:0]              out_sig,
    output logic                       out_inexact,
    output logic                       out_overflow,
    output logic                       out_badra
`ifdef ROUND_ARB_STATS_EN
    ,
    output logic [15:0]                stat_cnt0,
    output logic [15:0]                stat_cnt1,
    output logic [15:0]                stat_inexact
`endif
);

    localparam int EXPW = NEXP + 2;
    localparam int SIGW = NSIG + 1;
    localparam int DROP = INTn - SIGW;

    // One-hot rounding attribute bit positions.
    localparam int RA_RNE = 0;
    localparam int RA_RNA = 1;
    localparam int RA_RTP = 2;
    localparam int RA_RTN = 3;
    localparam int RA_RTZ = 4;

    localparam logic signed [EXPW-1:0] EMAX = EXPW'((1 << (NEXP - 1)) - 1);
    localparam logic [NRAS:0] RA_RTZ_OH = {1'b1, {NRAS{1'b0}}};

    // S0 operand register
    logic                   valid0_q, valid0_d;
    logic                   id0_q, id0_d;
    logic                   neg0_q, neg0_d;
    logic signed [EXPW-1:0] exp0_q, exp0_d;
    logic [INTn-1:0]        sig0_q, sig0_d;
    logic [NRAS:0]          ra0_q, ra0_d;

    // S1 result register
    logic                   out_valid_q, out_valid_d;
    logic                   out_id_q, out_id_d;
    logic                   out_neg_q, out_neg_d;
    logic [EXPW-1:0]        out_exp_q, out_exp_d;
    logic [SIGW-1:0]        out_sig_q, out_sig_d;
    logic                   out_inexact_q, out_inexact_d;
    logic                   out_overflow_q, out_overflow_d;
    logic                   out_badra_q, out_badra_d;

    logic                   lp_q, lp_d;

    logic [1:0]             grant;
    logic                   adv0, adv1;
    logic                   accept;
    logic                   acc_id;

    // Rounding datapath signals
    logic [SIGW-1:0]        keep;
    logic                   guard, sticky, lsb;
    logic                   rnd_badra;
    logic [NRAS:0]          ra_eff;
    logic                   rnd_up;
    logic [SIGW:0]          sum;
    logic [SIGW-1:0]        rnd_sig;
    logic signed [EXPW-1:0] rnd_exp;
    logic                   rnd_inexact;
    logic                   rnd_overflow;

    //--------------------------------------------------------------------
    // Arbitration and stage advance
    //--------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = lp_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign adv1      = ~out_valid_q | out_ready;
    assign adv0      = ~valid0_q | adv1;
    // Gated by rst_n so no handshake can complete while reset is asserted.
    assign req_ready = grant & {2{adv0 & rst_n}};
    assign accept    = |req_ready;
    assign acc_id    = req_ready[1];

    assign lp_d = accept ? acc_id : lp_q;

    //--------------------------------------------------------------------
    // S0 next state
    //--------------------------------------------------------------------
    always_comb begin
        valid0_d = valid0_q;
        id0_d    = id0_q;
        neg0_d   = neg0_q;
        exp0_d   = exp0_q;
        sig0_d   = sig0_q;
        ra0_d    = ra0_q;
        if (accept) begin
            valid0_d = 1'b1;
            id0_d    = acc_id;
            neg0_d   = req_neg[acc_id];
            exp0_d   = acc_id ? req_exp[2*EXPW-1 -: EXPW] : req_exp[EXPW-1:0];
            sig0_d   = acc_id ? req_sig[2*INTn-1 -: INTn] : req_sig[INTn-1:0];
            ra0_d    = acc_id ? req_ra[2*(NRAS+1)-1 -: NRAS+1] : req_ra[NRAS:0];
        end else if (adv1) begin
            valid0_d = 1'b0;
        end
    end

    //--------------------------------------------------------------------
    // Shared rounding datapath (single instance, S0 -> S1)
    //--------------------------------------------------------------------
    always_comb begin
        keep        = sig0_q[INTn-1 -: SIGW];
        guard       = sig0_q[DROP-1];
        sticky      = |sig0_q[DROP-2:0];
        lsb         = keep[0];
        rnd_badra   = ~$onehot(ra0_q);
        ra_eff      = rnd_badra ? RA_RTZ_OH : ra0_q;
        rnd_up      = (ra_eff[RA_RNE] & guard & (sticky | lsb))
                    | (ra_eff[RA_RNA] & guard)
                    | (ra_eff[RA_RTP] & ~neg0_q & (guard | sticky))
                    | (ra_eff[RA_RTN] &  neg0_q & (guard | sticky))
                    | (ra_eff[RA_RTZ] & 1'b0);
        sum         = {1'b0, keep} + {{SIGW{1'b0}}, rnd_up};
        rnd_inexact = guard | sticky;
        // A carry out of the significand renormalises to 1.000... and bumps the exponent.
        if (sum[SIGW]) begin
            rnd_sig = sum[SIGW:1];
            rnd_exp = exp0_q + {{(EXPW-1){1'b0}}, 1'b1};
        end else begin
            rnd_sig = sum[SIGW-1:0];
            rnd_exp = exp0_q;
        end
        rnd_overflow = rnd_exp > EMAX;
    end

    //--------------------------------------------------------------------
    // S1 next state
    //--------------------------------------------------------------------
    always_comb begin
        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_neg_d      = out_neg_q;
        out_exp_d      = out_exp_q;
        out_sig_d      = out_sig_q;
        out_inexact_d  = out_inexact_q;
        out_overflow_d = out_overflow_q;
        out_badra_d    = out_badra_q;
        if (adv1) begin
            out_valid_d = valid0_q;
            if (valid0_q) begin
                out_id_d       = id0_q;
                out_neg_d      = neg0_q;
                out_exp_d      = rnd_exp;
                out_sig_d      = rnd_sig;
                out_inexact_d  = rnd_inexact;
                out_overflow_d = rnd_overflow;
                out_badra_d    = rnd_badra;
            end
        end
    end

    //--------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_q       <= 1'b0;
            id0_q          <= 1'b0;
            neg0_q         <= 1'b0;
            exp0_q         <= '0;
            sig0_q         <= '0;
            ra0_q          <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= 1'b0;
            out_neg_q      <= 1'b0;
            out_exp_q      <= '0;
            out_sig_q      <= '0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
            out_badra_q    <= 1'b0;
            lp_q           <= 1'b1;
        end else begin
            valid0_q       <= valid0_d;
            id0_q          <= id0_d;
            neg0_q         <= neg0_d;
            exp0_q         <= exp0_d;
            sig0_q         <= sig0_d;
            ra0_q          <= ra0_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_neg_q      <= out_neg_d;
            out_exp_q      <= out_exp_d;
            out_sig_q      <= out_sig_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
            out_badra_q    <= out_badra_d;
            lp_q           <= lp_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_neg      = out_neg_q;
    assign out_exp      = out_exp_q;
    assign out_sig      = out_sig_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;
    assign out_badra    = out_badra_q;

`ifdef ROUND_ARB_STATS_EN
    logic        fire;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic [15:0] cnti_q, cnti_d;

    assign fire = out_valid_q & out_ready;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        cnti_d = cnti_q;
        if (fire) begin
            if (!out_id_q && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
            if ( out_id_q && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
            if (out_inexact_q && cnti_q != 16'hFFFF) cnti_d = cnti_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            cnti_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            cnti_q <= cnti_d;
        end
    end

    assign stat_cnt0    = cnt0_q;
    assign stat_cnt1    = cnt1_q;
    assign stat_inexact = cnti_q;
`endif

endmodule

// File: tb/tb_round_arbiter.sv
// Scoreboard bench for round_arbiter: accepts push expected results, a
// separate monitor pops and compares on every out_valid & out_ready.
module tb_round_arbiter;

    localparam logic [4:0] RNE = 5'b00001;
    localparam logic [4:0] RTN = 5'b01000;
    localparam logic [4:0] RTZ = 5'b10000;

    typedef struct packed {
        logic        id;
        logic        neg;
        logic [9:0]  exp;
        logic [23:0] sig;
        logic        inx;
        logic        ov;
        logic        bad;
    } res_t;

    typedef struct packed {
        logic        neg;
        logic [9:0]  exp;
        logic [31:0] sig;
        logic [4:0]  ra;
        res_t        r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_neg;
    logic [19:0] req_exp;
    logic [63:0] req_sig;
    logic [9:0]  req_ra;
    logic        out_valid, out_ready, out_id, out_neg;
    logic [9:0]  out_exp;
    logic [23:0] out_sig;
    logic        out_inexact, out_overflow, out_badra;
`ifdef ROUND_ARB_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1, stat_inexact;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    vec_t l0q[$];
    vec_t l1q[$];

    round_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_neg(req_neg),
        .req_exp(req_exp), .req_sig(req_sig), .req_ra(req_ra),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_neg(out_neg), .out_exp(out_exp), .out_sig(out_sig),
        .out_inexact(out_inexact), .out_overflow(out_overflow), .out_badra(out_badra)
`ifdef ROUND_ARB_STATS_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_inexact(stat_inexact)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic neg, input logic [9:0] e, input logic [31:0] s,
                                 input logic [4:0] ra, input logic [23:0] esig,
                                 input logic [9:0] eexp, input logic einx,
                                 input logic eov, input logic ebad);
        vec_t v;
        v.neg = neg; v.exp = e; v.sig = s; v.ra = ra;
        v.r = '{id: 1'b0, neg: neg, exp: eexp, sig: esig, inx: einx, ov: eov, bad: ebad};
        return v;
    endfunction

    // Lane 0 stream: exact values, result equals the truncated significand.
    function automatic vec_t l0v(input int k);
        return mkv(1'b0, 10'(k), 32'h8000_0000 + 32'(k << 8), RNE,
                   24'h800000 + 24'(k), 10'(k), 1'b0, 1'b0, 1'b0);
    endfunction

    // Lane 1 stream: negative, sticky only, RTN rounds magnitude up by one.
    function automatic vec_t l1v(input int k);
        return mkv(1'b1, 10'(10 + k), 32'hC000_0040 + 32'(k << 8), RTN,
                   24'hC00001 + 24'(k), 10'(10 + k), 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive_cycle(input logic [1:0] en, input logic ordy, output logic [1:0] acc);
        vec_t v0, v1;
        res_t r;
        @(negedge clk);
        v0 = (l0q.size() > 0) ? l0q[0] : '0;
        v1 = (l1q.size() > 0) ? l1q[0] : '0;
        out_ready = ordy;
        req_valid = {en[1] && (l1q.size() > 0), en[0] && (l0q.size() > 0)};
        req_neg   = {v1.neg, v0.neg};
        req_exp   = {v1.exp, v0.exp};
        req_sig   = {v1.sig, v0.sig};
        req_ra    = {v1.ra, v0.ra};
        #4;
        acc = req_ready;
        checks++;
        if ((acc & ~req_valid) != 2'b00 || acc == 2'b11) begin
            errors++;
            $display("FAIL ready_legal got=%b valid=%b", acc, req_valid);
        end
        if (acc[0]) begin r = v0.r; r.id = 1'b0; sb.push_back(r); void'(l0q.pop_front()); end
        if (acc[1]) begin r = v1.r; r.id = 1'b1; sb.push_back(r); void'(l1q.pop_front()); end
    endtask

    task automatic send(input logic lane, input vec_t v);
        logic [1:0] acc;
        bit         done = 0;
        if (lane) l1q.push_back(v); else l0q.push_back(v);
        for (int i = 0; i < 10 && !done; i++) begin
            drive_cycle(lane ? 2'b10 : 2'b01, 1'b1, acc);
            done = (acc != 2'b00);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout lane=%0d got=none want=accept", lane);
        end
    endtask

    task automatic drain();
        logic [1:0] acc;
        for (int i = 0; i < 20 && sb.size() != 0; i++) drive_cycle(2'b00, 1'b1, acc);
        drive_cycle(2'b00, 1'b1, acc);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
        end
    endtask

    // Monitor: pops on every handshake and checks output stability during stalls.
    initial begin
        res_t cur, snap, want;
        bit   stall_prev = 0;
        snap = '0;
        forever begin
            @(negedge clk); #4;
            cur = '{id: out_id, neg: out_neg, exp: out_exp, sig: out_sig,
                    inx: out_inexact, ov: out_overflow, bad: out_badra};
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!out_valid || cur !== snap) begin
                        errors++;
                        $display("FAIL hold_stable got=%b/%h want=1/%h", out_valid, cur, snap);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result got=%h want=none", cur);
                    end else begin
                        want = sb.pop_front();
                        if (cur !== want) begin
                            errors++;
                            $display("FAIL result got id=%0d neg=%0d exp=%h sig=%h inx=%0d ov=%0d bad=%0d want id=%0d neg=%0d exp=%h sig=%h inx=%0d ov=%0d bad=%0d",
                                     cur.id, cur.neg, cur.exp, cur.sig, cur.inx, cur.ov, cur.bad,
                                     want.id, want.neg, want.exp, want.sig, want.inx, want.ov, want.bad);
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                snap = cur;
            end
        end
    end

    initial begin
        logic [1:0] acc;
        logic [1:0] exp_seq [4];
        int         nacc;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

        rst_n = 1'b0; out_ready = 1'b0; req_valid = 2'b00; req_neg = '0;
        req_exp = '0; req_sig = '0; req_ra = '0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #4;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'({out_id, out_neg, out_exp, out_sig, out_inexact, out_overflow, out_badra}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;

        // Contention from reset: lane 0 wins the first tie, then alternation.
        l0q.push_back(l0v(1)); l0q.push_back(l0v(2));
        l1q.push_back(l1v(1)); l1q.push_back(l1v(2));
        for (int i = 0; i < 4; i++) begin
            drive_cycle(2'b11, 1'b1, acc);
            chk($sformatf("grant_order_%0d", i), 64'(acc), 64'(exp_seq[i]));
        end
        drain();

        // Exact value on lane 0 with two-cycle latency.
        l0q.push_back(mkv(1'b0, 10'd0, 32'h8000_0000, RNE, 24'h800000, 10'd0, 1'b0, 1'b0, 1'b0));
        drive_cycle(2'b01, 1'b1, acc);
        chk("exact_accept", 64'(acc), 64'b01);
        drive_cycle(2'b00, 1'b1, acc);
        chk("latency_n1", 64'(out_valid), 64'd0);
        drive_cycle(2'b00, 1'b1, acc);
        chk("latency_n2", 64'(out_valid), 64'd1);
        drain();

        // RNE carry, RTZ and bad rounding attribute.
        send(1'b1, mkv(1'b0, 10'd5, 32'hFFFF_FF80, RNE, 24'h800000, 10'd6, 1'b1, 1'b0, 1'b0));
        send(1'b1, mkv(1'b0, 10'd5, 32'hFFFF_FF80, RTZ, 24'hFFFFFF, 10'd5, 1'b1, 1'b0, 1'b0));
        send(1'b0, mkv(1'b0, 10'd5, 32'hFFFF_FF80, 5'b00000, 24'hFFFFFF, 10'd5, 1'b1, 1'b0, 1'b1));
        send(1'b0, mkv(1'b0, 10'd5, 32'hFFFF_FF80, 5'b00011, 24'hFFFFFF, 10'd5, 1'b1, 1'b0, 1'b1));
        drain();

        // Backpressure with both lanes streaming.
        for (int k = 3; k <= 5; k++) begin l0q.push_back(l0v(k)); l1q.push_back(l1v(k)); end
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(2'b11, 1'b0, acc);
            nacc += $countones(acc);
        end
        chk("stall_accepts", 64'(nacc), 64'd2);
        for (int i = 0; i < 20 && (l0q.size() + l1q.size()) != 0; i++)
            drive_cycle(2'b11, 1'b1, acc);
        chk("stream_done", 64'(l0q.size() + l1q.size()), 64'd0);
        drain();

        // Overflow after rounding carry.
        send(1'b0, mkv(1'b0, 10'd127, 32'hFFFF_FFFF, RNE, 24'h800000, 10'd128, 1'b1, 1'b1, 1'b0));
        drain();

        // Reset while an operand sits in S0: it must never emerge.
        send(1'b0, l0v(7));
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete(); l0q.delete(); l1q.delete();
        req_valid = 2'b11;
        #4;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        repeat (5) drive_cycle(2'b00, 1'b1, acc);
        chk("post_reset_idle", 64'(out_valid), 64'd0);

        // Pointer restored by reset: lane 0 wins the first tie again.
        l0q.push_back(l0v(8)); l1q.push_back(l1v(8));
        drive_cycle(2'b11, 1'b1, acc);
        chk("post_reset_grant", 64'(acc), 64'b01);
        drive_cycle(2'b11, 1'b1, acc);
        chk("post_reset_grant2", 64'(acc), 64'b10);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
